// File: rtl/acc_stream_nb.sv
// Frame accumulator: sums N_W+1-bit adder results into ACC_W bits over CNT_MAX samples or until flush.
// Optional macro ACC_SAT_EN: clamp accumulator to all-ones on overflow instead of wrapping.
module acc_stream_nb #(
  parameter int N_W     = 16,
  parameter int ACC_W   = 24,
  parameter int CNT_MAX = 8,
  localparam int CW     = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W:0]     in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CW-1:0]    out_cnt,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_last;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_acc;
  assign out_cnt   = r_cnt;
  assign out_ovf   = r_ovf;

  assign w_accept = in_valid && in_ready;
  // One extra bit on the sum so the carry out of ACC_W is the overflow flag.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W - N_W){1'b0}}, in_data};
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_last   = (w_cnt_nx == CW'(CNT_MAX));

`ifdef ACC_SAT_EN
  // Once clamped the accumulator stays at all-ones for the rest of the frame.
  assign w_acc_nx = (w_sum[ACC_W] || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_nx = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            r_acc <= w_acc_nx;
            r_cnt <= w_cnt_nx;
            r_ovf <= r_ovf | w_sum[ACC_W];
          end
          // Flush only counts once the frame holds a sample; a coincident sample is folded in first.
          if (w_accept && w_last)
            r_state <= S_HOLD;
          else if (flush && r_state == S_ACC)
            r_state <= S_HOLD;
          else if (w_accept)
            r_state <= S_ACC;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_stream_nb.sv
// Scoreboard bench for acc_stream_nb: frame-level reference model feeds an expected queue, a monitor checks outputs.
module tb_acc_stream_nb;

  localparam int NW  = 16;
  localparam int AW  = 24;
  localparam int CM  = 4;
  localparam int CW  = $clog2(CM + 1);
  localparam int AW2 = 17;
  localparam int CM2 = 2;
  localparam int CW2 = $clog2(CM2 + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready, out_ovf;
  logic [NW:0]   in_data;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_cnt;

  logic           b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_ovf;
  logic [NW:0]    b_in_data;
  logic [AW2-1:0] b_out_data;
  logic [CW2-1:0] b_out_cnt;

  always #5 clk = ~clk;

  acc_stream_nb #(.N_W(NW), .ACC_W(AW), .CNT_MAX(CM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_ovf(out_ovf));

  acc_stream_nb #(.N_W(NW), .ACC_W(AW2), .CNT_MAX(CM2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_cnt(b_out_cnt), .out_ovf(b_out_ovf));

  typedef struct { longint d; int c; bit o; } exp_t;

  exp_t   sb[$];
  longint frame[$];
  bit     m_hold;
  int     tests = 0;
  int     fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result from the arithmetic total: wrap modulo 2^accw, or clamp when saturating.
  function automatic exp_t frame_exp(input longint q[$], input int accw);
    exp_t   e;
    longint tot = 0;
    longint mx  = (longint'(1) << accw) - 1;
    foreach (q[i]) tot += q[i];
    e.c = q.size();
    e.o = (tot > mx);
`ifdef ACC_SAT_EN
    e.d = e.o ? mx : tot;
`else
    e.d = tot & mx;
`endif
    return e;
  endfunction

  // Monitor: compares the held result every cycle it is presented, retires it on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("out_data", out_data, sb[0].d);
        chk("out_cnt", out_cnt, sb[0].c);
        chk("out_ovf", out_ovf, sb[0].o);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input logic [NW:0] d, input bit f, input bit r);
    bit was_acc;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(negedge clk);
    chk("in_ready", in_ready, !m_hold);
    chk("out_valid", out_valid, m_hold);
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      was_acc = (frame.size() > 0);
      if (v) frame.push_back(longint'(d));
      if (frame.size() == CM || (f && was_acc)) begin
        sb.push_back(frame_exp(frame, AW));
        frame.delete();
        m_hold = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if (m_hold) void'(sb.pop_back());
    frame.delete();
    m_hold = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t e2;
    longint q2[$];
    rst = 1'b1;
    in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_flush = 0; b_out_ready = 1;
    m_hold = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Overflow case on the narrow instance.
    for (int i = 0; i < 2; i++) begin
      b_in_valid = 1; b_in_data = 17'h1FFFE;
      q2.push_back(64'h1FFFE);
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    e2 = frame_exp(q2, AW2);
    @(negedge clk);
    chk("b_out_valid", b_out_valid, 1);
    chk("b_out_data", b_out_data, e2.d);
    chk("b_out_cnt", b_out_cnt, e2.c);
    chk("b_out_ovf", b_out_ovf, e2.o);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_out_valid_clr", b_out_valid, 0);
    @(posedge clk); #1;

    // Back-to-back 1..4.
    for (int i = 1; i <= 4; i++) cyc(1, 17'(i), 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // 5,6 then flush; flush while idle; 5 then 7 with flush.
    cyc(1, 5, 0, 1); cyc(1, 6, 0, 1); cyc(0, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 5, 0, 1); cyc(1, 7, 1, 1); cyc(0, 0, 0, 1);

    // Back-pressure for 10 cycles with the source still offering samples.
    for (int i = 0; i < 4; i++) cyc(1, 17'(100 + i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 17'h1234, 0, 0);
    cyc(1, 17'h55, 0, 1);
    cyc(1, 17'h1, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    // Reset mid-frame discards the partial sum.
    cyc(1, 9, 0, 1); cyc(1, 9, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);

    // Reset while a result is pending.
    for (int i = 0; i < 4; i++) cyc(1, 3, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 120) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, 17'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
